// File: rtl/missile_controller.sv
// missile_controller: fixed pool of player missiles, sequenced once per frame.
// Spawns a missile at the ship nose on the fire key, moves every live missile
// up by MISSILE_STEP each frame, and retires it at the top edge or on a hit.
// Optional build macro MISSILE_AUTOFIRE_EN: when defined, holding the fire key
// re-fires each time the cooldown expires instead of needing a fresh press.
module missile_controller #(
  parameter int         NUM_MISSILES    = 4,
  parameter int         MISSILE_STEP    = 4,
  parameter int         COOLDOWN_FRAMES = 8,
  parameter logic [7:0] FIRE_KEY        = 8'h2C,
  parameter int         Y_MIN           = 0
) (
  input  logic                         frame_clk,
  input  logic                         Reset,
  input  logic [7:0]                   keycode,
  input  logic [9:0]                   ShipX,
  input  logic [9:0]                   ShipY,
  input  logic [9:0]                   ShipSY,
  input  logic [NUM_MISSILES-1:0]      Hit,
  output logic [10*NUM_MISSILES-1:0]   MissileX,
  output logic [10*NUM_MISSILES-1:0]   MissileY,
  output logic [NUM_MISSILES-1:0]      MissileActive,
  output logic [3:0]                   ActiveCount,
  output logic                         FireDrop
);

  // Rows below this value cannot take another full step, so the missile retires.
  localparam logic [9:0] RETIRE_BELOW = 10'(Y_MIN + MISSILE_STEP);
  localparam logic [9:0] STEP_10      = 10'(MISSILE_STEP);
  localparam logic [7:0] CD_LOAD      = 8'(COOLDOWN_FRAMES);

  logic [7:0]                  prev_key;
  logic [7:0]                  cooldown;
  logic                        edge_ok;
  logic                        fire_req;
  logic                        slot_free;
  logic                        do_spawn;
  logic [NUM_MISSILES-1:0]     spawn_mask;
  logic [9:0]                  ship_top;
  logic [NUM_MISSILES-1:0]     nx_active;
  logic [10*NUM_MISSILES-1:0]  nx_x;
  logic [10*NUM_MISSILES-1:0]  nx_y;
  logic [3:0]                  nx_count;
  logic [7:0]                  nx_cooldown;

`ifdef MISSILE_AUTOFIRE_EN
  // Held key re-fires whenever the cooldown allows it.
  assign edge_ok = 1'b1;
`else
  // Only a fresh press (key absent on the previous frame) fires.
  assign edge_ok = (prev_key != FIRE_KEY);
`endif

  assign fire_req = (keycode == FIRE_KEY) && edge_ok && (cooldown == 8'd0);
  assign ship_top = ShipY - ShipSY;

  // Pick the lowest slot that was idle before this edge; slots freed this
  // same edge are deliberately not considered.
  always_comb begin
    spawn_mask = '0;
    slot_free  = 1'b0;
    for (int i = 0; i < NUM_MISSILES; i++) begin
      if (!MissileActive[i] && !slot_free) begin
        spawn_mask[i] = 1'b1;
        slot_free     = 1'b1;
      end
    end
  end

  assign do_spawn = fire_req && slot_free;

  // Per-slot next state: spawn, hit, retire or move; X is written only on spawn.
  always_comb begin
    nx_active = MissileActive;
    nx_x      = MissileX;
    nx_y      = MissileY;
    nx_count  = 4'd0;
    for (int i = 0; i < NUM_MISSILES; i++) begin
      if (do_spawn && spawn_mask[i]) begin
        nx_active[i]      = 1'b1;
        nx_x[10*i +: 10]  = ShipX;
        nx_y[10*i +: 10]  = ship_top;
      end else if (MissileActive[i]) begin
        if (Hit[i]) begin
          nx_active[i] = 1'b0;
        end else if (MissileY[10*i +: 10] < RETIRE_BELOW) begin
          nx_active[i] = 1'b0;
        end else begin
          nx_y[10*i +: 10] = MissileY[10*i +: 10] - STEP_10;
        end
      end
      nx_count = nx_count + {3'b000, nx_active[i]};
    end
  end

  // Cooldown reloads only on an actual spawn, otherwise counts down to zero.
  always_comb begin
    nx_cooldown = cooldown;
    if (do_spawn) begin
      nx_cooldown = CD_LOAD;
    end else if (cooldown != 8'd0) begin
      nx_cooldown = cooldown - 8'd1;
    end
  end

  // Frame-rate state register; reset wins over everything on its edge.
  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      MissileActive <= '0;
      MissileX      <= '0;
      MissileY      <= '0;
      ActiveCount   <= 4'd0;
      FireDrop      <= 1'b0;
      cooldown      <= 8'd0;
      prev_key      <= 8'd0;
    end else begin
      MissileActive <= nx_active;
      MissileX      <= nx_x;
      MissileY      <= nx_y;
      ActiveCount   <= nx_count;
      FireDrop      <= fire_req && !slot_free;
      cooldown      <= nx_cooldown;
      prev_key      <= keycode;
    end
  end

endmodule

// File: tb/tb_missile_controller.sv
// tb_missile_controller: directed scenarios plus randomized frames, every frame
// compared against a behavioural model of the missile pool.
module tb_missile_controller;

  localparam int         N    = 4;
  localparam int         STEP = 4;
  localparam int         CD   = 8;
  localparam logic [7:0] FK   = 8'h2C;
  localparam int         YMIN = 0;

  // ---------------- clock / reset / DUT ----------------
  logic              frame_clk = 1'b0;
  logic              Reset     = 1'b1;
  logic [7:0]        keycode   = 8'd0;
  logic [9:0]        ShipX     = 10'd0;
  logic [9:0]        ShipY     = 10'd0;
  logic [9:0]        ShipSY    = 10'd0;
  logic [N-1:0]      Hit       = '0;
  logic [10*N-1:0]   MissileX;
  logic [10*N-1:0]   MissileY;
  logic [N-1:0]      MissileActive;
  logic [3:0]        ActiveCount;
  logic              FireDrop;

  always #5 frame_clk = ~frame_clk;

  missile_controller #(
    .NUM_MISSILES(N), .MISSILE_STEP(STEP), .COOLDOWN_FRAMES(CD),
    .FIRE_KEY(FK), .Y_MIN(YMIN)
  ) dut (
    .frame_clk(frame_clk), .Reset(Reset), .keycode(keycode),
    .ShipX(ShipX), .ShipY(ShipY), .ShipSY(ShipSY), .Hit(Hit),
    .MissileX(MissileX), .MissileY(MissileY), .MissileActive(MissileActive),
    .ActiveCount(ActiveCount), .FireDrop(FireDrop)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // ---------------- reference model ----------------
  bit         m_act [N];
  logic [9:0] m_x   [N];
  logic [9:0] m_y   [N];
  int         m_cd;
  logic [7:0] m_pk;
  bit         m_drop;

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_act[i] = 1'b0; m_x[i] = '0; m_y[i] = '0;
    end
    m_cd = 0; m_pk = 8'd0; m_drop = 1'b0;
  endtask

  // One frame of pool behaviour from the rules: fire request, lowest idle
  // slot, then hit / retire / move for slots already in flight.
  task automatic model_step(input logic rst, input logic [7:0] key, input logic [N-1:0] hit);
    bit fire;
    int free;
    if (rst) begin
      model_reset();
      return;
    end
`ifdef MISSILE_AUTOFIRE_EN
    fire = (key == FK) && (m_cd == 0);
`else
    fire = (key == FK) && (m_pk != FK) && (m_cd == 0);
`endif
    free = -1;
    for (int i = 0; i < N; i++) if (!m_act[i] && free < 0) free = i;
    for (int i = 0; i < N; i++) begin
      if (m_act[i]) begin
        if (hit[i]) m_act[i] = 1'b0;
        else if (int'(m_y[i]) < YMIN + STEP) m_act[i] = 1'b0;
        else m_y[i] = m_y[i] - 10'(STEP);
      end
    end
    if (fire && free >= 0) begin
      m_act[free] = 1'b1;
      m_x[free]   = ShipX;
      m_y[free]   = ShipY - ShipSY;
      m_cd        = CD;
      m_drop      = 1'b0;
    end else begin
      m_drop = fire;
      if (m_cd > 0) m_cd--;
    end
    m_pk = key;
  endtask

  task automatic compare_all(input string tag);
    logic [10*N-1:0] ex, ey;
    logic [N-1:0]    ea;
    int              cnt;
    cnt = 0;
    for (int i = 0; i < N; i++) begin
      ex[10*i +: 10] = m_x[i];
      ey[10*i +: 10] = m_y[i];
      ea[i]          = m_act[i];
      cnt += int'(m_act[i]);
    end
    check_eq({tag, ".active"}, 64'(MissileActive), 64'(ea));
    check_eq({tag, ".x"},      64'(MissileX),      64'(ex));
    check_eq({tag, ".y"},      64'(MissileY),      64'(ey));
    check_eq({tag, ".count"},  64'(ActiveCount),   64'(cnt));
    check_eq({tag, ".drop"},   64'(FireDrop),      64'(m_drop));
  endtask

  // ---------------- driver ----------------
  task automatic step(input string tag, input logic rst, input logic [7:0] key, input logic [N-1:0] hit);
    @(negedge frame_clk);
    Reset = rst; keycode = key; Hit = hit;
    @(posedge frame_clk);
    model_step(rst, key, hit);
    #1;
    compare_all(tag);
  endtask

  task automatic idle(input string tag, input int n);
    for (int k = 0; k < n; k++) step(tag, 1'b0, 8'd0, '0);
  endtask

  // ---------------- scenarios ----------------
  logic [7:0] exp_q[$];

  initial begin
    int edges;
    int prev_cnt;
    model_reset();

    // Reset state
    step("reset", 1'b1, 8'd0, '0);
    check_eq("reset.active0", 64'(MissileActive), 64'd0);

    // First spawn at the ship nose, then one move
    ShipX = 10'd320; ShipY = 10'd360; ShipSY = 10'd25;
    step("spawn", 1'b0, FK, '0);
    check_eq("spawn.y0", 64'(MissileY[9:0]), 64'd335);
    check_eq("spawn.x0", 64'(MissileX[9:0]), 64'd320);
    check_eq("spawn.cnt", 64'(ActiveCount), 64'd1);
    step("move", 1'b0, 8'd0, '0);
    check_eq("move.y0", 64'(MissileY[9:0]), 64'd331);

    // Fly to the top edge and retire
    edges = 1;
    while (MissileActive[0] && edges < 200) begin
      step("fly", 1'b0, 8'd0, '0);
      edges++;
    end
    check_eq("retire.edges", 64'(edges), 64'd84);
    check_eq("retire.yhold", 64'(MissileY[9:0]), 64'd3);

    // Fill the pool, then a fifth press drops
    step("reset2", 1'b1, 8'd0, '0);
    ShipX = 10'd100; ShipY = 10'd500; ShipSY = 10'd10;
    for (int p = 0; p < 5; p++) begin
      step("fill", 1'b0, FK, '0);
      if (p < 4) check_eq("fill.mask", 64'(MissileActive), 64'((1 << (p + 1)) - 1));
      else       check_eq("fill.drop", 64'(FireDrop), 64'd1);
      step("fill_rel", 1'b0, 8'd0, '0);
      if (p == 4) check_eq("fill.drop_clear", 64'(FireDrop), 64'd0);
      idle("fill_idle", 8);
    end

    // Hit on slot1 with a press on the same edge: slot not reusable yet
    step("hit", 1'b0, FK, 4'b0010);
    check_eq("hit.drop", 64'(FireDrop), 64'd1);
    check_eq("hit.mask", 64'(MissileActive), 64'hD);
    step("hit_rel", 1'b0, 8'd0, '0);
    step("refill", 1'b0, FK, '0);
    check_eq("refill.mask", 64'(MissileActive), 64'hF);
    check_eq("refill.y1", 64'(MissileY[19:10]), 64'd490);

    // Held key for 30 frames
    step("reset3", 1'b1, 8'd0, '0);
`ifdef MISSILE_AUTOFIRE_EN
    exp_q = '{8'd0, 8'd9, 8'd18, 8'd27};
`else
    exp_q = '{8'd0};
`endif
    prev_cnt = 0;
    for (int f = 0; f < 30; f++) begin
      step("hold", 1'b0, FK, '0);
      if (int'(ActiveCount) > prev_cnt) begin
        if (exp_q.size() == 0) check_eq("hold.extra_spawn", 64'(f), 64'hFF);
        else check_eq("hold.spawn_frame", 64'(f), 64'(exp_q.pop_front()));
      end
      prev_cnt = int'(ActiveCount);
    end
    check_eq("hold.missing", 64'(exp_q.size()), 64'd0);
    step("hold_rel", 1'b0, 8'd0, '0);

    // Reset mid-flight with cooldown running, then immediate respawn
    step("reset4", 1'b1, 8'd0, '0);
    for (int p = 0; p < 3; p++) begin
      step("pre", 1'b0, FK, '0);
      idle("pre_idle", (p < 2) ? 9 : 2);
    end
    check_eq("pre.cnt", 64'(ActiveCount), 64'd3);
    step("midreset", 1'b1, FK, '0);
    check_eq("midreset.mask", 64'(MissileActive), 64'd0);
    check_eq("midreset.y", 64'(MissileY), 64'd0);
    step("post", 1'b0, FK, '0);
    check_eq("post.mask", 64'(MissileActive), 64'd1);

    // Randomized frames
    for (int t = 0; t < 700; t++) begin
      logic [7:0]   k;
      logic [N-1:0] h;
      logic         r;
      ShipX  = 10'($urandom_range(0, 639));
      ShipY  = 10'($urandom_range(0, 479));
      ShipSY = 10'($urandom_range(0, 40));
      case ($urandom_range(0, 3))
        0, 1:    k = FK;
        2:       k = 8'd0;
        default: k = 8'($urandom_range(0, 255));
      endcase
      h = ($urandom_range(0, 3) == 0) ? N'($urandom_range(0, 15)) : '0;
      r = ($urandom_range(0, 99) == 0);
      step("rand", r, k, h);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/missile_controller.md
Name: missile_controller

Overview:
- Owns a fixed pool of player missiles for the spaceship and sequences them once per frame: spawn on the fire key, move upward, retire at the top edge or on a hit.
- Sits beside the ship movement block and takes the ship position/size outputs.
- Feeds missile positions to the colour mapper and collision logic; collision logic returns per-slot hit pulses.

Parameters:
- NUM_MISSILES, 4, number of missile slots in the pool (1..8)
- MISSILE_STEP, 4, pixels a missile moves up per frame
- COOLDOWN_FRAMES, 8, minimum frames between two spawns
- FIRE_KEY, 8'h2C, keycode that fires (space)
- Y_MIN, 0, topmost screen row

Ports:
- frame_clk  in  1  frame clock; all state updates on its rising edge
- Reset  in  1  synchronous, active-high reset
- keycode  in  8  current keyboard keycode
- ShipX  in  10  ship centre X
- ShipY  in  10  ship centre Y
- ShipSY  in  10  ship half-height
- Hit  in  NUM_MISSILES  per-slot hit from collision logic; sampled each edge
- MissileX  out  10*NUM_MISSILES  slot i X at bits [10i+9:10i]
- MissileY  out  10*NUM_MISSILES  slot i Y, same packing
- MissileActive  out  NUM_MISSILES  slot i live
- ActiveCount  out  4  number of set MissileActive bits
- FireDrop  out  1  one-frame pulse when a fire request finds no free slot

Behaviour:
- Reset (synchronous, active-high) takes priority over everything on that edge. Afterwards:
  - MissileActive, MissileX, MissileY, ActiveCount = 0
  - FireDrop = 0, cooldown counter = 0, key-history register = 0
- Reset asserted mid-flight clears all slots on that edge.
- Fire request at an edge: fire_req = (keycode == FIRE_KEY) AND (prev_key != FIRE_KEY) AND (cooldown == 0).
  - prev_key is keycode registered on the previous edge.
- Allocation: the lowest-index slot whose MissileActive was 0 before this edge.
  - A slot freed on this same edge by Hit or retire is not reusable until the next edge.
- Spawn, on the same edge as the request:
  - slot X <= ShipX; slot Y <= ShipY - ShipSY (10-bit unsigned, truncating); slot active <= 1; cooldown <= COOLDOWN_FRAMES.
  - Latency 0: visible on the outputs after that edge.
  - A spawned missile does not move on its spawn edge.
- Drop: fire_req with no free slot sets FireDrop = 1 for that frame only. Cooldown is not loaded on a drop.
- Cooldown counter: decrements by 1 on each edge while nonzero; saturates at 0.
- Move: each active slot not spawned and not hit this edge:
  - if Y < Y_MIN + MISSILE_STEP, clear active (retire); else Y <= Y - MISSILE_STEP.
  - The comparison is unsigned, so no wrap below 0 is possible.
- Hit[i] on an active slot clears active on that edge. It overrides move and retire. Hit[i] on an inactive slot is ignored.
- X of a slot never changes after spawn. X/Y of an inactive slot hold their last values.
- ActiveCount is registered and reflects MissileActive after the same edge.
- Only FIRE_KEY is decoded; all other keycodes are ignored.

Optional Feature:
- Macro MISSILE_AUTOFIRE_EN.
- Defined: the prev_key edge term is dropped. Holding FIRE_KEY spawns every time cooldown reaches 0, i.e. every COOLDOWN_FRAMES+1 edges, until the key is released or the pool is full.
- Undefined: the key must be released and pressed again to fire. A held key yields exactly one missile.

Test Plan:
- Reset, ShipX=320, ShipY=360, ShipSY=25, press 8'h2C for one edge -> slot0 active, X=320, Y=335, ActiveCount=1, cooldown=8. Next edge: Y=331.
- Single missile, 84 frames with no hit (Y: 335 → ... → 3) -> slot0 retires on the 85th edge, when Y=3 < 4. MissileActive=0; Y holds 3.
- Five press/release cycles, each spaced 10 frames -> slots 0..3 fill in order. Fifth press gives FireDrop=1 for exactly one frame and no state change.
- Slot1 active, assert Hit=4'b0010 for one edge -> slot1 cleared. A press on that same edge with slots 0, 2, 3 busy gives FireDrop; a press one edge later spawns into slot1.
- Hold 8'h2C for 30 frames, MISSILE_AUTOFIRE_EN undefined -> exactly 1 spawn. Defined -> spawns at frames 0, 9, 18, 27.
- Assert Reset while 3 missiles are active and the cooldown is nonzero -> everything is 0 after that edge. A fresh press on the next edge spawns into slot0 immediately.
